// File: rtl/pc_pkg.sv
// Shared types and default parameter values for the fetch PC generator.
package pc_pkg;

  localparam int unsigned XLEN_DEF       = 32;
  localparam int unsigned RESET_VEC_DEF  = 0;
  localparam int unsigned INC_DEF        = 4;
  localparam int unsigned ALIGN_BITS_DEF = 2;
  localparam int unsigned CNT_W_DEF      = 16;

  typedef enum logic [1:0] {
    PC_SEQ,
    PC_BR,
    PC_TRAP
  } pc_sel_e;

endpackage

// File: rtl/pc_gen_if.sv
// Redirect/stall controls in, fetch PC and decode-stage PC out.
interface pc_gen_if
  import pc_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
);

  logic              STALL;
  logic              FLUSH;
  logic              TRAP_EN;
  logic [XLEN-1:0]   TRAP_VEC;
  logic              BR_EN;
  logic [XLEN-1:0]   BR_TGT;
  logic [XLEN-1:0]   PC_OUT;
  logic [XLEN-1:0]   PC_NEXT_SEQ;
  logic [XLEN-1:0]   IFID_PC;
  logic              IFID_VALID;
  logic              MISALIGN;
  logic [CNT_W-1:0]  REDIR_CNT;

  modport master (
    output STALL, FLUSH, TRAP_EN, TRAP_VEC, BR_EN, BR_TGT,
    input  PC_OUT, PC_NEXT_SEQ, IFID_PC, IFID_VALID, MISALIGN, REDIR_CNT
  );

  modport slave (
    input  STALL, FLUSH, TRAP_EN, TRAP_VEC, BR_EN, BR_TGT,
    output PC_OUT, PC_NEXT_SEQ, IFID_PC, IFID_VALID, MISALIGN, REDIR_CNT
  );

endinterface

// File: rtl/pc_ifid_reg.sv
// IF/ID pipeline register: kill beats hold, hold beats load.
module pc_ifid_reg #(
  parameter int unsigned XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            HOLD,
  input  logic            KILL,
  input  logic [XLEN-1:0] D_PC,
  output logic [XLEN-1:0] Q_PC,
  output logic            Q_VALID
);

  logic [XLEN-1:0] pc_d, pc_q;
  logic            valid_d, valid_q;

  // A killed slot keeps its old PC; only the valid bit drops.
  always_comb begin
    pc_d    = pc_q;
    valid_d = valid_q;
    if (KILL) begin
      valid_d = 1'b0;
    end else if (!HOLD) begin
      pc_d    = D_PC;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign Q_PC    = pc_q;
  assign Q_VALID = valid_q;

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: trap > branch > sequential select, IF/ID register,
// alignment check and saturating redirect counter.
module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN       = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VEC  = XLEN'(RESET_VEC_DEF),
  parameter int unsigned     INC        = INC_DEF,
  parameter int unsigned     ALIGN_BITS = ALIGN_BITS_DEF,
  parameter int unsigned     CNT_W      = CNT_W_DEF
) (
  input logic     CLK,
  input logic     RST_N,
  pc_gen_if.slave bus
);

  localparam logic [XLEN-1:0]  ALIGN_MASK = XLEN'((64'(1) << ALIGN_BITS) - 64'(1));
  localparam logic [XLEN-1:0]  INC_V      = XLEN'(INC);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  pc_sel_e          sel_c;
  logic [XLEN-1:0]  tgt_c;
  logic             redir_c;
  logic [XLEN-1:0]  pc_d, pc_q;
  logic             mis_d, mis_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Next-PC select; redirects override STALL, only the winning target is checked.
  always_comb begin
    sel_c   = PC_SEQ;
    tgt_c   = pc_q;
    redir_c = 1'b0;
    pc_d    = pc_q;
    mis_d   = 1'b0;
    cnt_d   = cnt_q;

    if (bus.TRAP_EN)    sel_c = PC_TRAP;
    else if (bus.BR_EN) sel_c = PC_BR;

    case (sel_c)
      PC_TRAP: tgt_c = bus.TRAP_VEC;
      PC_BR:   tgt_c = bus.BR_TGT;
      default: tgt_c = pc_q;
    endcase

    redir_c = (sel_c != PC_SEQ);

    if (redir_c) begin
      pc_d  = tgt_c & ~ALIGN_MASK;
      mis_d = |(tgt_c & ALIGN_MASK);
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
    end else if (!bus.STALL) begin
      pc_d = pc_q + INC_V;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc_q  <= RESET_VEC;
      mis_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      mis_q <= mis_d;
      cnt_q <= cnt_d;
    end
  end

  pc_ifid_reg #(.XLEN(XLEN)) u_ifid (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .HOLD    (bus.STALL),
    .KILL    (redir_c | bus.FLUSH),
    .D_PC    (pc_q),
    .Q_PC    (bus.IFID_PC),
    .Q_VALID (bus.IFID_VALID)
  );

  assign bus.PC_OUT      = pc_q;
  assign bus.PC_NEXT_SEQ = pc_q + INC_V;
  assign bus.MISALIGN    = mis_q;
  assign bus.REDIR_CNT   = cnt_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed table, hand sequences, random vs model.
module tb_pc_gen;
  import pc_pkg::*;

  localparam longint unsigned MOD = 64'h1_0000_0000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pc_gen_if #(.XLEN(32), .CNT_W(16)) bif ();
  pc_gen_if #(.XLEN(32), .CNT_W(2))  sif ();

  assign sif.STALL    = bif.STALL;
  assign sif.FLUSH    = bif.FLUSH;
  assign sif.TRAP_EN  = bif.TRAP_EN;
  assign sif.TRAP_VEC = bif.TRAP_VEC;
  assign sif.BR_EN    = bif.BR_EN;
  assign sif.BR_TGT   = bif.BR_TGT;

  pc_gen #(.XLEN(32), .CNT_W(16)) dut (.CLK(clk), .RST_N(rst_n), .bus(bif.slave));
  pc_gen #(.XLEN(32), .CNT_W(2))  dut_sat (.CLK(clk), .RST_N(rst_n), .bus(sif.slave));

  int checks = 0;
  int failures = 0;

  longint unsigned m_pc, m_ifid_pc;
  bit              m_v, m_mis;
  int unsigned     m_cnt;

  typedef struct {
    bit          stall;
    bit          flush;
    bit          trap_en;
    logic [31:0] trap_vec;
    bit          br_en;
    logic [31:0] br_tgt;
    logic [31:0] e_pc;
    logic [31:0] e_ifid;
    bit          e_v;
    bit          e_mis;
    int unsigned e_cnt;
  } vec_t;

  vec_t vec [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit st, input bit fl, input bit te, input logic [31:0] tv,
                       input bit be, input logic [31:0] bt);
    bif.STALL = st; bif.FLUSH = fl; bif.TRAP_EN = te;
    bif.TRAP_VEC = tv; bif.BR_EN = be; bif.BR_TGT = bt;
  endtask

  task automatic model_reset();
    m_pc = 0; m_ifid_pc = 0; m_v = 0; m_mis = 0; m_cnt = 0;
  endtask

  // Advance the reference model by one edge from the currently driven inputs.
  task automatic tick();
    longint unsigned t;
    bit redir;
    redir = bif.TRAP_EN || bif.BR_EN;
    t = bif.TRAP_EN ? 64'(bif.TRAP_VEC) : 64'(bif.BR_TGT);
    if (redir || bif.FLUSH) m_v = 0;
    else if (!bif.STALL) begin m_ifid_pc = m_pc; m_v = 1; end
    m_mis = redir && (t % 4 != 0);
    if (redir) m_pc = t - (t % 4);
    else if (!bif.STALL) m_pc = (m_pc + 4) % MOD;
    if (redir && m_cnt < 65535) m_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic compare_all(input string tag);
    int unsigned sat;
    sat = (m_cnt > 3) ? 3 : m_cnt;
    check({tag, ".pc"},       64'(bif.PC_OUT),      64'(m_pc));
    check({tag, ".next_seq"}, 64'(bif.PC_NEXT_SEQ), (m_pc + 4) % MOD);
    check({tag, ".ifid_pc"},  64'(bif.IFID_PC),     64'(m_ifid_pc));
    check({tag, ".ifid_v"},   64'(bif.IFID_VALID),  64'(m_v));
    check({tag, ".misalign"}, 64'(bif.MISALIGN),    64'(m_mis));
    check({tag, ".cnt"},      64'(bif.REDIR_CNT),   64'(m_cnt));
    check({tag, ".sat_pc"},   64'(sif.PC_OUT),      64'(m_pc));
    check({tag, ".sat_nxt"},  64'(sif.PC_NEXT_SEQ), (m_pc + 4) % MOD);
    check({tag, ".sat_ifid"}, 64'(sif.IFID_PC),     64'(m_ifid_pc));
    check({tag, ".sat_v"},    64'(sif.IFID_VALID),  64'(m_v));
    check({tag, ".sat_mis"},  64'(sif.MISALIGN),    64'(m_mis));
    check({tag, ".sat_cnt"},  64'(sif.REDIR_CNT),   64'(sat));
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 32'h0, 0, 32'h0);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst.pc",   64'(bif.PC_OUT),     64'h0);
    check("rst.ifid", 64'(bif.IFID_PC),    64'h0);
    check("rst.v",    64'(bif.IFID_VALID), 64'h0);
    check("rst.mis",  64'(bif.MISALIGN),   64'h0);
    check("rst.cnt",  64'(bif.REDIR_CNT),  64'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    //           st fl te tvec          be btgt          pc            ifid          v  mis cnt
    vec[0]  = '{0, 0, 0, 32'h0,        0, 32'h0,        32'h4,        32'h0,        1, 0, 0};
    vec[1]  = '{0, 0, 0, 32'h0,        0, 32'h0,        32'h8,        32'h4,        1, 0, 0};
    vec[2]  = '{1, 0, 0, 32'h0,        1, 32'h100,      32'h100,      32'h4,        0, 0, 1};
    vec[3]  = '{0, 0, 1, 32'h200,      1, 32'h102,      32'h200,      32'h4,        0, 0, 2};
    vec[4]  = '{0, 0, 0, 32'h0,        1, 32'h103,      32'h100,      32'h4,        0, 1, 3};
    vec[5]  = '{0, 0, 0, 32'h0,        0, 32'h0,        32'h104,      32'h100,      1, 0, 3};
    vec[6]  = '{1, 0, 0, 32'h0,        0, 32'h0,        32'h104,      32'h100,      1, 0, 3};
    vec[7]  = '{0, 1, 0, 32'h0,        0, 32'h0,        32'h108,      32'h100,      0, 0, 3};
    vec[8]  = '{1, 1, 0, 32'h0,        0, 32'h0,        32'h108,      32'h100,      0, 0, 3};
    vec[9]  = '{0, 0, 0, 32'h0,        0, 32'h0,        32'h10C,      32'h108,      1, 0, 3};
    vec[10] = '{1, 0, 1, 32'h301,      1, 32'h400,      32'h300,      32'h108,      0, 1, 4};
    vec[11] = '{0, 0, 1, 32'h600,      1, 32'h501,      32'h600,      32'h108,      0, 0, 5};

    do_reset();
    check("init.pc",  64'(bif.PC_OUT),      64'h0);
    check("init.nxt", 64'(bif.PC_NEXT_SEQ), 64'h4);

    for (int i = 0; i < 12; i++) begin
      drive(vec[i].stall, vec[i].flush, vec[i].trap_en, vec[i].trap_vec,
            vec[i].br_en, vec[i].br_tgt);
      tick();
      check($sformatf("vec%0d.pc", i),   64'(bif.PC_OUT),     64'(vec[i].e_pc));
      check($sformatf("vec%0d.ifid", i), 64'(bif.IFID_PC),    64'(vec[i].e_ifid));
      check($sformatf("vec%0d.v", i),    64'(bif.IFID_VALID), 64'(vec[i].e_v));
      check($sformatf("vec%0d.mis", i),  64'(bif.MISALIGN),   64'(vec[i].e_mis));
      check($sformatf("vec%0d.cnt", i),  64'(bif.REDIR_CNT),  64'(vec[i].e_cnt));
      check($sformatf("vec%0d.sat", i),  64'(sif.REDIR_CNT),
            64'((vec[i].e_cnt > 3) ? 3 : vec[i].e_cnt));
    end

    // Wrap from the top of the address space.
    drive(0, 0, 0, 32'h0, 1, 32'hFFFF_FFFC);
    tick();
    check("wrap.pre", 64'(bif.PC_OUT), 64'hFFFF_FFFC);
    check("wrap.nxt", 64'(bif.PC_NEXT_SEQ), 64'h0);
    drive(0, 0, 0, 32'h0, 0, 32'h0);
    tick();
    check("wrap.pc",  64'(bif.PC_OUT),   64'h0);
    check("wrap.mis", 64'(bif.MISALIGN), 64'h0);
    compare_all("wrap");

    // Asynchronous reset between edges, with a redirect pending.
    drive(0, 0, 0, 32'h0, 1, 32'h123);
    tick();
    check("pre_rst.mis", 64'(bif.MISALIGN), 64'h1);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst.pc",      64'(bif.PC_OUT),     64'h0);
    check("arst.ifid",    64'(bif.IFID_PC),    64'h0);
    check("arst.v",       64'(bif.IFID_VALID), 64'h0);
    check("arst.mis",     64'(bif.MISALIGN),   64'h0);
    check("arst.cnt",     64'(bif.REDIR_CNT),  64'h0);
    check("arst.sat_cnt", 64'(sif.REDIR_CNT),  64'h0);
    @(posedge clk);
    #2;
    drive(0, 0, 0, 32'h0, 0, 32'h0);
    model_reset();
    rst_n = 1'b1;
    tick();
    check("post_rst.pc",   64'(bif.PC_OUT),     64'h4);
    check("post_rst.ifid", 64'(bif.IFID_PC),    64'h0);
    check("post_rst.v",    64'(bif.IFID_VALID), 64'h1);
    compare_all("post_rst");

    // Random traffic against the reference model.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      logic [31:0] tv, bt;
      tv = $urandom;
      bt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 9) == 0, tv, $urandom_range(0, 5) == 0, bt);
      tick();
      compare_all($sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
